mdriver_arbiter: RTL and testbench

//   Round-robin arbiter that shares one mdriver_int master port (the exec/we/fin

---
 rtl/mdriver_arbiter_if.sv | 32 +++
 rtl/mdriver_arbiter.sv | 145 ++++++++++++++
 tb/tb_mdriver_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdriver_arbiter_if.sv
// Bus bundle between requesters, the round-robin arbiter and the single mdriver_int master.
// slave = arbiter view, master = view of the environment driving requests and answering fin.
interface mdriver_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   busy;
  logic                   m_exec;
  logic                   m_we;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_wdata;
  logic [DATA_W-1:0]      m_rdata;
  logic                   m_fin;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, m_rdata, m_fin,
    output req_ready, rsp_valid, rsp_rdata, busy, m_exec, m_we, m_addr, m_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, m_rdata, m_fin,
    input  req_ready, rsp_valid, rsp_rdata, busy, m_exec, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mdriver_arbiter.sv
// Round-robin arbiter sharing one exec/we/fin master port among NREQ requesters.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module mdriver_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nreset,
  mdriver_arbiter_if.slave  bus
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_last;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   w_winner;
  logic              w_found;
  logic              w_accept;
  logic              w_fin_seen;
  logic [NREQ-1:0]   w_ready;
  int                w_idx;
  logic              r_m_exec;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_busy;

  assign w_accept   = (r_state == ST_IDLE) && w_found;
  assign w_fin_seen = (r_state == ST_WAIT) && bus.m_fin;

  // Round-robin search starting one past the last grant, wrapping at NREQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = int'(r_last) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(w_idx);
      end else begin
        w_found  = w_found;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; m_fin only matters while waiting.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.m_fin) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Accept strobe is combinational so the requester sees it in the accept cycle.
  always_comb begin
    w_ready = '0;
    if (w_accept) begin
      w_ready = NREQ'(1) << w_winner;
    end else begin
      w_ready = '0;
    end
  end

  // Master-side and response registers; m_* deliberately hold their value in IDLE.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_last      <= ID_W'(NREQ - 1);
      r_id        <= '0;
      r_m_exec    <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_m_exec <= w_accept;
      r_busy   <= (w_state_nxt != ST_IDLE);
      if (w_accept) begin
        r_m_we    <= bus.req_we[w_winner];
        r_m_addr  <= bus.req_addr[w_winner*ADDR_W +: ADDR_W];
        r_m_wdata <= bus.req_wdata[w_winner*DATA_W +: DATA_W];
        r_id      <= w_winner;
        r_last    <= w_winner;
      end
      if (w_fin_seen) begin
        r_rsp_valid <= NREQ'(1) << r_id;
        r_rsp_rdata <= r_m_we ? {DATA_W{1'b0}} : bus.m_rdata;
      end else begin
        r_rsp_valid <= '0;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.busy      = r_busy;
  assign bus.m_exec    = r_m_exec;
  assign bus.m_we      = r_m_we;
  assign bus.m_addr    = r_m_addr;
  assign bus.m_wdata   = r_m_wdata;
endmodule

// File: tb/tb_mdriver_arbiter.sv
// Scoreboard bench for mdriver_arbiter: a memory-backed master model answers exec with fin,
// accepted requests are queued with expected results and compared when rsp_valid pulses.
module tb_mdriver_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  mdriver_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mdriver_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Master model: answers each exec with fin after fin_delay cycles, backed by mem.
  logic        fin_model = 1'b0;
  logic        fin_inj   = 1'b0;
  logic [31:0] rdata_model = 32'h0;
  logic [31:0] mem [0:255];
  int          fin_delay = 1;
  bit          m_pend = 1'b0;
  int          m_cnt = 0;

  assign bus.m_fin   = fin_model | fin_inj;
  assign bus.m_rdata = rdata_model;

  always begin
    @(posedge clk);
    #2;
    if (!nreset) begin
      m_pend    = 1'b0;
      fin_model = 1'b0;
    end else begin
      if (fin_model) fin_model = 1'b0;
      if (m_pend) begin
        if (m_cnt == 0) begin
          m_pend    = 1'b0;
          fin_model = 1'b1;
          if (bus.m_we) begin
            mem[bus.m_addr[7:0]] = bus.m_wdata;
            rdata_model = 32'hFFFF_FFFF;
          end else begin
            rdata_model = mem[bus.m_addr[7:0]];
          end
        end else begin
          m_cnt--;
        end
      end
      if (bus.m_exec) begin
        m_pend = 1'b1;
        m_cnt  = fin_delay - 1;
      end
    end
  end

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
  } txn_t;

  txn_t sb[$];
  txn_t cur;
  txn_t mt;
  bit   active = 1'b0;
  bit   ready_prev = 1'b0;
  int   exec_cnt = 0;
  int   rsp_cnt = 0;
  int   rsp_ids[$];

  // Monitor: push expectations on accept, pop and compare on each response pulse.
  always @(negedge clk) begin
    if (!nreset) begin
      sb.delete();
      active     = 1'b0;
      ready_prev = 1'b0;
    end else begin
      if (ready_prev) check_eq("exec_after_accept", bus.m_exec, 1);
      if (bus.m_exec) exec_cnt++;
      if (active) begin
        check_eq("m_addr_hold", bus.m_addr, cur.addr);
        check_eq("m_we_hold", bus.m_we, cur.we);
        check_eq("m_wdata_hold", bus.m_wdata, cur.wdata);
        check_eq("busy_in_txn", bus.busy, 1);
      end
      if (bus.rsp_valid != '0) begin
        rsp_cnt++;
        for (int i = 0; i < NREQ; i++) if (bus.rsp_valid[i]) rsp_ids.push_back(i);
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          mt = sb.pop_front();
          check_eq("rsp_id", bus.rsp_valid, 64'(1) << mt.id);
          check_eq("rsp_rdata", bus.rsp_rdata, mt.data);
          check_eq("exec_count", exec_cnt, 1);
        end
        active = 1'b0;
      end
      ready_prev = 1'b0;
      if (bus.req_ready != '0) begin
        check_eq("ready_onehot", $countones(bus.req_ready), 1);
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) mt.id = i;
        mt.we    = bus.req_we[mt.id];
        mt.addr  = bus.req_addr[mt.id*AW +: AW];
        mt.wdata = bus.req_wdata[mt.id*DW +: DW];
        mt.data  = mt.we ? 32'h0 : mem[mt.addr[7:0]];
        sb.push_back(mt);
        cur        = mt;
        active     = 1'b1;
        exec_cnt   = 0;
        ready_prev = 1'b1;
      end
    end
  end

  task automatic set_req(input int id, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_we[id]               = we;
    bus.req_addr[id*AW +: AW]    = addr;
    bus.req_wdata[id*DW +: DW]   = wdata;
    bus.req_valid[id]            = 1'b1;
  endtask

  task automatic issue(input int id, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #2;
    set_req(id, we, addr, wdata);
    repeat (100) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("accept_timeout", ok, 1);
    @(posedge clk);
    #2;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    repeat (300) begin
      @(negedge clk);
      #1;
      if (rsp_cnt >= target) break;
    end
    check_eq("rsp_timeout", rsp_cnt >= target, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_exec"}, bus.m_exec, 0);
    check_eq({tag, "_we"}, bus.m_we, 0);
    check_eq({tag, "_addr"}, bus.m_addr, 0);
    check_eq({tag, "_wdata"}, bus.m_wdata, 0);
    check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check_eq({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    bit ok;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEAD_BEEF;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    check_eq("reset_ready", bus.req_ready, 0);
    nreset = 1'b1;

    // 1: req0 read of 0x10
    fin_delay = 3;
    issue(0, 1'b0, 32'h10, 32'h0);
    wait_rsp(1);
    check_eq("t1_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);

    // 2: req1 write, then readback through req0
    issue(1, 1'b1, 32'h20, 32'h1234_5678);
    wait_rsp(2);
    check_eq("t2_wr_rdata", bus.rsp_rdata, 32'h0);
    check_eq("t2_mem", mem[8'h20], 32'h1234_5678);
    issue(0, 1'b0, 32'h20, 32'h0);
    wait_rsp(3);
    check_eq("t2_readback", bus.rsp_rdata, 32'h1234_5678);
    issue(1, 1'b0, 32'h10, 32'h0);
    wait_rsp(4);

    // 3: both requesters continuously valid, last grant was req1
    base = rsp_ids.size();
    @(posedge clk);
    #2;
    set_req(0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 32'h20, 32'h0);
    repeat (400) begin
      @(negedge clk);
      #1;
      if (rsp_cnt >= 10) break;
    end
    bus.req_valid = '0;
    check_eq("t3_count_reached", rsp_cnt >= 10, 1);
    repeat (4) @(negedge clk);
    check_eq("t3_no_extra", rsp_cnt, 10);
    for (int i = 0; i < 6; i++) begin
      if (base + i < rsp_ids.size()) check_eq("t3_order", rsp_ids[base + i], i % 2);
      else check_eq("t3_order_missing", base + i, rsp_ids.size());
    end

    // 4: stray fin in IDLE and in ISSUE is ignored
    @(posedge clk);
    #2;
    fin_inj = 1'b1;
    @(posedge clk);
    #2;
    fin_inj = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t4_idle_busy", bus.busy, 0);
    check_eq("t4_idle_rsp", rsp_cnt, 10);
    fin_delay = 5;
    @(posedge clk);
    #2;
    set_req(0, 1'b0, 32'h10, 32'h0);
    ok = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.req_ready[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("t4_accept", ok, 1);
    @(posedge clk);
    #2;
    bus.req_valid[0] = 1'b0;
    fin_inj = 1'b1;
    @(posedge clk);
    #2;
    fin_inj = 1'b0;
    @(negedge clk);
    check_eq("t4_issue_busy", bus.busy, 1);
    check_eq("t4_issue_rsp", bus.rsp_valid, 0);
    wait_rsp(11);
    check_eq("t4_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);

    // 5: reset in WAIT drops the transaction
    fin_delay = 50;
    issue(0, 1'b0, 32'h10, 32'h0);
    repeat (3) @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    check_eq("t5_ready", bus.req_ready, 0);
    repeat (2) @(posedge clk);
    #2;
    nreset = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("t5_dropped", rsp_cnt, 11);
    fin_delay = 2;
    @(posedge clk);
    #2;
    set_req(0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 32'h20, 32'h0);
    #1;
    check_eq("t5_first_grant", bus.req_ready, 2'b01);
    bus.req_valid[1] = 1'b0;
    @(posedge clk);
    #2;
    bus.req_valid[0] = 1'b0;
    wait_rsp(12);
    check_eq("t5_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);

    // 6: slow fin, everything held and no accept while busy
    fin_delay = 20;
    issue(0, 1'b1, 32'h30, 32'hA5A5_A5A5);
    set_req(1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("t6_busy", bus.busy, 1);
      check_eq("t6_ready", bus.req_ready, 0);
      check_eq("t6_addr", bus.m_addr, 32'h30);
      check_eq("t6_wdata", bus.m_wdata, 32'hA5A5_A5A5);
      check_eq("t6_we", bus.m_we, 1);
    end
    ok = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.req_ready[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("t6_req1_accept", ok, 1);
    @(posedge clk);
    #2;
    bus.req_valid[1] = 1'b0;
    wait_rsp(14);
    check_eq("t6_mem", mem[8'h30], 32'hA5A5_A5A5);
    check_eq("t6_rdata", bus.rsp_rdata, 32'h1234_5678);
    check_eq("sb_empty", sb.size(), 0);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
